// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The line is brought into the clk domain through a two-flop synchronizer.
// A five-state FSM then finds the falling edge of the start bit and samples
// each bit once, at its centre. Every output is registered.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] parallel_out,
  output logic       data_valid,
  output logic       framing_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic [1:0]       sync_q;
  logic             rx_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       po_nxt;
  logic             dv_nxt, fe_nxt;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer. It resets to the idle-high line level so that
  // leaving reset cannot look like a start edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, whatever order the simulator runs the
    // blocks in.
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in};
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is a small flop vector, not a RAM, so it is
    // cleared along with the rest of the state.
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      parallel_out  <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      shift         <= shift_nxt;
      parallel_out  <= po_nxt;
      data_valid    <= dv_nxt;
      framing_error <= fe_nxt;
    end
  end

  // Next-state logic and bit sampling. Sampling happens only when the bit
  // counter reaches its terminal count, so any activity between bit centres
  // is ignored.
  always_comb begin
    // NOTE: every signal gets a default here first. That way no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    po_nxt    = parallel_out;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end

      START: begin
        if (cnt == CNT_HALF_LAST) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          // The line is back high at the centre of the start bit, so the
          // low level was a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_BIT_LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == CNT_BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            po_nxt    = shift;
            dv_nxt    = 1'b1;
            // Return to IDLE at the stop-bit centre. A start bit that follows
            // the stop bit directly is then still caught.
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        cnt_nxt = '0;
        // A broken frame may leave the line low. Wait for it to go high
        // before watching for the next start edge.
        if (rx_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 50 MHz / 115200 baud.
// The bench builds frames on serial_in. Each frame it sends puts the outcome
// it must produce into a queue: a data byte or a framing error, plus the cycle
// it is due. One compare process checks the outputs on every falling clock
// edge against that queue and against the last good byte.
module tb_uart_rx;

  localparam int CPB  = 50_000_000 / 115_200;  // 434
  localparam int HALF = CPB / 2;               // 217
  // Line edge driven after posedge C: two synchronizer flops, then the FSM
  // reacts at C+3; stop sample registers at +HALF+9*CPB.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] parallel_out;
  logic       data_valid;
  logic       framing_error;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_seen = 1'b1;
  logic [7:0] model_po = 8'h00;
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  exp_t exp_q[$];

  uart_rx dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .parallel_out  (parallel_out),
    .data_valid    (data_valid),
    .framing_error (framing_error)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: the outputs against the expected-event queue and the byte model.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst_seen) model_po = 8'h00;
    if (data_valid && framing_error)
      check("dv_fe_overlap", {data_valid, framing_error}, 2'b00);
    if (data_valid || framing_error) begin
      if (data_valid)    dv_cnt++;
      if (framing_error) fe_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {data_valid, framing_error}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {data_valid, framing_error}, e.is_err ? 2'b01 : 2'b10);
        total++;
        if (cyc < e.due - 1 || cyc > e.due + 1) begin
          bad++;
          $display("FAIL pulse_time: got cycle %0d expected %0d +/-1", cyc, e.due);
        end
        if (!e.is_err) begin
          check("rx_byte", parallel_out, e.data);
          model_po = e.data;
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
      e = exp_q.pop_front();
      check("missing_pulse", 0, 1);
    end
    check("parallel_out_hold", parallel_out, model_po);
  end

  // Drive one bit period. An optional short inverted pulse is placed well
  // before the bit centre.
  task automatic drive_bit(input logic v, input bit glitch);
    serial_in = v;
    for (int i = 0; i < CPB; i++) begin
      if (glitch && i == 20) serial_in = ~v;
      if (glitch && i == 25) serial_in = v;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stop_low: number of bit periods the stop bit is held low (0 = good frame).
  // abort_bit: data bit during which rst is pulsed (-1 = none).
  task automatic send_frame(input logic [7:0] b, input int stop_low,
                            input int abort_bit, input bit glitch);
    exp_t e;
    e.is_err = (stop_low > 0);
    e.data   = b;
    e.due    = cyc + LAT;
    if (abort_bit < 0) exp_q.push_back(e);
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        serial_in = b[i];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        serial_in = 1'b1;
        return;
      end
      drive_bit(b[i], glitch);
    end
    for (int i = 0; i < stop_low; i++) drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, glitch);
  endtask

  initial begin : stim
    int dv0, fe0;
    logic [7:0] rb;
    int gap;

    repeat (5) @(posedge clk);
    #1;
    check("reset_po", parallel_out, 8'h00);
    check("reset_dv", data_valid, 1'b0);
    check("reset_fe", framing_error, 1'b0);
    rst = 1'b0;
    idle(100);

    // Single byte 0x37.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h37, 0, -1, 1'b0);
    idle(2 * CPB);
    check("b37_value", parallel_out, 8'h37);
    check("b37_dv_count", dv_cnt - dv0, 1);
    check("b37_fe_count", fe_cnt - fe0, 0);

    // Back-to-back 0xFF then 0x00 with no idle gap.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hFF, 0, -1, 1'b0);
    send_frame(8'h00, 0, -1, 1'b0);
    idle(2 * CPB);
    check("b2b_dv_count", dv_cnt - dv0, 2);
    check("b2b_value", parallel_out, 8'h00);

    // 2000 ns low glitch: the start bit is rejected.
    dv0 = dv_cnt; fe0 = fe_cnt;
    serial_in = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(2 * CPB);
    check("glitch_dv_count", dv_cnt - dv0, 0);
    check("glitch_fe_count", fe_cnt - fe0, 0);

    // 0xA5 with the stop bit held low for two bits, then 0x5A.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 2, -1, 1'b0);
    idle(CPB);
    check("ferr_fe_count", fe_cnt - fe0, 1);
    check("ferr_dv_count", dv_cnt - dv0, 0);
    check("ferr_po_kept", parallel_out, 8'h00);
    send_frame(8'h5A, 0, -1, 1'b0);
    idle(2 * CPB);
    check("after_ferr_value", parallel_out, 8'h5A);

    // Reset pulse during data bit 4, then 0xC3.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h96, 0, 4, 1'b0);
    idle(2 * CPB);
    check("abort_dv_count", dv_cnt - dv0, 0);
    check("abort_fe_count", fe_cnt - fe0, 0);
    check("abort_po", parallel_out, 8'h00);
    send_frame(8'hC3, 0, -1, 1'b0);
    idle(2 * CPB);
    check("after_abort_value", parallel_out, 8'hC3);

    // Long reset with the line idle.
    dv0 = dv_cnt; fe0 = fe_cnt;
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("long_rst_po", parallel_out, 8'h00);
    check("long_rst_dv", data_valid, 1'b0);
    check("long_rst_fe", framing_error, 1'b0);
    rst = 1'b0;
    idle(3 * CPB);
    check("long_rst_no_pulse", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
    check("long_rst_po_after", parallel_out, 8'h00);

    // Random frames: random bytes and gaps, mid-bit glitches, some bad stop bits.
    for (int k = 0; k < 6; k++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
      if (gap > 0) idle(gap);
      send_frame(rb, ($urandom_range(0, 3) == 0) ? 1 : 0, -1, 1'($urandom_range(0, 1)));
    end
    idle(2 * CPB);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000; clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200; serial bit rate in bits/s.
REQ-003 Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD with integer truncation (434 at defaults); HALF_BIT = CLKS_PER_BIT/2 (217).
REQ-004 clk  input  1  single clock, rising-edge active, all logic in this domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 serial_in  input  1  asynchronous UART line; idles high.
REQ-007 parallel_out  output  8  last correctly framed received byte.
REQ-008 data_valid  output  1  one-cycle pulse when parallel_out is updated.
REQ-009 framing_error  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-010 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 serial_in SHALL pass through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; one bit counter (0..CLKS_PER_BIT-1) and one 3-bit index.
REQ-013 IDLE: when rx_s=0, go to START with counter cleared; otherwise stay.
REQ-014 START: after HALF_BIT-1 more clocks, sample rx_s; if 0 go to DATA (counter cleared, index 0); if 1, treat as glitch and return to IDLE with no output pulse.
REQ-015 DATA: every CLKS_PER_BIT clocks, shift rx_s into shift register bit [index]; after index 7, go to STOP.
REQ-016 STOP: after CLKS_PER_BIT clocks, sample rx_s; if 1, load parallel_out from shift register, pulse data_valid for exactly one cycle, go to IDLE.
REQ-017 STOP sample 0: pulse framing_error for one cycle, leave parallel_out unchanged, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rx_s=1, then go to IDLE; no new start is detected while in this state.
REQ-019 Return to IDLE occurs at the stop-bit mid-sample, so a start bit immediately following a stop bit (back-to-back frames) SHALL be received.
REQ-020 Sampling points SHALL be at the bit centre: start edge + HALF_BIT + n*CLKS_PER_BIT clocks, plus 2-clock synchronizer delay.
REQ-021 data_valid SHALL assert 2 + HALF_BIT + 9*CLKS_PER_BIT clocks (+/-1) after the line's falling start edge.
REQ-022 parallel_out SHALL hold its value between valid frames; data_valid and framing_error SHALL never assert in the same cycle.
REQ-023 Input changes during mid-bit counting SHALL be ignored; only centre samples matter.

Reset
REQ-024 While rst=1 on a rising clk edge: state IDLE, counters 0, shift register 0, parallel_out 8'h00, data_valid 0, framing_error 0, synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; reception restarts at the next falling edge after rst deasserts.

Verification
REQ-026 At 50 MHz/115200, send 0x37 (8N1, 8680 ns/bit) -> one data_valid pulse, parallel_out=0x37, framing_error stays 0.
REQ-027 Send 0xFF then 0x00 back-to-back with no idle gap -> two data_valid pulses, parallel_out 0xFF then 0x00.
REQ-028 Drive serial_in low for 2000 ns then high -> no data_valid, no framing_error, FSM returns to IDLE.
REQ-029 Send 0xA5 with stop bit held 0 for two bit periods, then line high -> framing_error single pulse, parallel_out keeps prior value; a following 0x5A is received correctly.
REQ-030 Assert rst for one cycle during data bit 4 of a frame -> no pulse, parallel_out=0x00; a subsequent 0xC3 frame yields parallel_out=0xC3.
REQ-031 Hold rst high for 50 cycles with serial_in=1 -> all outputs 0, no pulses after release while the line idles.
